test_word_gen: RTL and testbench
================================

Name: test_word_gen

Overview:
Parametrised stimulus source for the SHA-256 datapath. It replaces the fixed 8-word test sequence with a configurable-length burst of message words. Words are delivered over a valid/ready stream with a last-word marker. Four generation modes are supported: legacy pattern table, incrementing counter, Galois LFSR and constant. The block sits in front of the message-schedule input during bring-up and regression.

Parameters:
WIDTH, 32, output word width in bits (8..64); table entries are truncated or zero-extended to WIDTH.
LEN_W, 6, width of the burst-length input; maximum burst is 2^LEN_W-1 words.
SEED, 32'h0000_0001, start value for INC, LFSR and CONST modes (low WIDTH bits used).
POLY, 32'h8020_0003, Galois LFSR feedback mask (x^32+x^22+x^2+x+1, right-shift form).

Ports:
C  input  1  clock; all state changes on rising edge.
R  input  1  asynchronous, active-low reset.
START  input  1  begin burst; sampled only in IDLE.
MODE  input  2  0=TABLE, 1=INC, 2=LFSR, 3=CONST; latched on accepted START.
LEN  input  LEN_W  number of words in burst; latched on accepted START.
READY  input  1  downstream accepts WORD this cycle.
WORD  output  WIDTH  current message word.
VALID  output  1  WORD is valid.
LAST  output  1  WORD is final word of burst (qualified by VALID).
BUSY  output  1  burst in progress (RUN or DONE state).
DONE  output  1  one-cycle pulse after final handshake.

Behaviour:
- Reset (R low, asynchronous): state=IDLE. WORD=0, VALID=0, LAST=0, BUSY=0, DONE=0. Generator state and index cleared. Reset mid-burst aborts with no DONE pulse.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE, START=1: latch MODE and LEN, load generator.
  - LEN==0: go to FIN; no word issued.
  - Otherwise go to RUN.
  - VALID rises the cycle after START (1-cycle latency) with the first word.
- RUN: VALID=1.
  - WORD and LAST are held stable while READY=0.
  - On VALID&READY: index+1 and the generator advances.
  - If LAST was 1, go to FIN and VALID drops next cycle. Otherwise the next word is presented in the following cycle, so one word per cycle is sustained with READY held high.
- FIN: DONE=1 for exactly one cycle, VALID=0, BUSY=1; then IDLE. BUSY=0 in IDLE.
- START outside IDLE is ignored. A START in the same cycle the FSM returns to IDLE is also ignored; it is only accepted with state==IDLE.
- LAST = (index == LEN_latched-1) while in RUN.
- TABLE mode:
  - Entries in order: 0000_0000, 0000_0001, 1234_5678, ABCD_EF00, BAD0_E0F0, FFFF_FFFF, 0128_0256, AAAA_AAAA.
  - Word k = entry[k mod 8]; wraps after entry 7.
- INC mode: first word = SEED; each subsequent word = previous+1, modulo 2^WIDTH (FFFF_FFFF -> 0000_0000).
- LFSR mode:
  - First word = SEED.
  - Next = (s>>1) ^ (s[0] ? POLY : 0).
  - If SEED==0, 1 is loaded instead, so the LFSR never locks up.
- CONST mode: every word = SEED.
- Generator reloads on every accepted START; no state carries across bursts.

Test Plan:
1. Reset-to-burst: R low then high; START, MODE=0, LEN=9, READY=1 -> WORD 0000_0000, 0000_0001, 1234_5678, ABCD_EF00, BAD0_E0F0, FFFF_FFFF, 0128_0256, AAAA_AAAA, 0000_0000 on consecutive cycles. LAST on 9th word only; DONE pulses one cycle after.
2. INC wrap: SEED=FFFF_FFFE, MODE=1, LEN=3 -> FFFF_FFFE, FFFF_FFFF, 0000_0000; LAST on third word.
3. LFSR: SEED=1, MODE=2, LEN=3 -> 0000_0001, 8020_0003, C030_0002.
4. Backpressure: MODE=0, LEN=4, READY toggled 1,0,0,1,1,0,1 -> WORD/LAST held while READY=0; exactly 4 handshakes, values as in scenario 1; no duplicate or dropped word.
5. Edge lengths: LEN=0 -> no VALID, DONE one cycle after START. LEN=1 -> single word with VALID and LAST together. START pulsed during RUN -> ignored, burst length unchanged.
6. Reset mid-burst: R low during word 3 of a LEN=8 burst -> VALID, BUSY and WORD go to 0 immediately with no DONE. A fresh START after reset restarts at table entry 0.

Source files
------------

// File: rtl/test_word_gen_if.sv
// rtl/test_word_gen_if.sv - stream and control bundle between the word generator and its consumer
interface test_word_gen_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 6
);
  logic             START;
  logic [1:0]       MODE;
  logic [LEN_W-1:0] LEN;
  logic             READY;
  logic [WIDTH-1:0] WORD;
  logic             VALID;
  logic             LAST;
  logic             BUSY;
  logic             DONE;

  // generator side: takes commands and backpressure, drives the word stream and status
  modport master (
    input  START, MODE, LEN, READY,
    output WORD, VALID, LAST, BUSY, DONE
  );

  // consumer side: issues commands and backpressure, receives the word stream and status
  modport slave (
    output START, MODE, LEN, READY,
    input  WORD, VALID, LAST, BUSY, DONE
  );
endinterface

// File: rtl/test_word_gen.sv
// rtl/test_word_gen.sv - configurable-length message word burst source (table, counter, LFSR, constant)
module test_word_gen #(
  parameter int          WIDTH = 32,
  parameter int          LEN_W = 6,
  parameter logic [31:0] SEED  = 32'h0000_0001,
  parameter logic [31:0] POLY  = 32'h8020_0003
) (
  input logic              C,
  input logic              R,
  test_word_gen_if.master  bus
);

  localparam logic [1:0] MODE_TABLE = 2'd0;
  localparam logic [1:0] MODE_INC   = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;

  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] POLY_W = WIDTH'(POLY);
  // an all-zero LFSR would never leave zero, so a zero seed starts it at 1
  localparam logic [WIDTH-1:0] LFSR_INIT = (SEED_W == '0) ? WIDTH'(1) : SEED_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] gen_q, gen_d;

  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] next_gen;
  logic             is_last;

  // legacy fixed pattern, indexed by the low three bits of the word index
  function automatic logic [WIDTH-1:0] table_entry(input logic [2:0] i);
    logic [31:0] e;
    case (i)
      3'd0:    e = 32'h0000_0000;
      3'd1:    e = 32'h0000_0001;
      3'd2:    e = 32'h1234_5678;
      3'd3:    e = 32'hABCD_EF00;
      3'd4:    e = 32'hBAD0_E0F0;
      3'd5:    e = 32'hFFFF_FFFF;
      3'd6:    e = 32'h0128_0256;
      default: e = 32'hAAAA_AAAA;
    endcase
    return WIDTH'(e);
  endfunction

  // table mode reads by index; the other modes present the generator register directly
  assign cur_word = (mode_q == MODE_TABLE) ? table_entry(idx_q[2:0]) : gen_q;
  assign is_last  = (idx_q == len_q - LEN_W'(1));

  // generator step applied on each accepted word; constant mode simply holds
  assign next_gen = (mode_q == MODE_INC)  ? gen_q + WIDTH'(1) :
                    (mode_q == MODE_LFSR) ? ((gen_q >> 1) ^ (gen_q[0] ? POLY_W : '0)) :
                    gen_q;

  // state register with asynchronous clear; reset mid-burst drops straight to idle
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      gen_q   <= gen_d;
    end
  end

  // next-state and stream outputs; WORD reads zero whenever no word is offered
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    idx_d     = idx_q;
    gen_d     = gen_q;
    bus.WORD  = '0;
    bus.VALID = 1'b0;
    bus.LAST  = 1'b0;
    bus.BUSY  = 1'b0;
    bus.DONE  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          mode_d  = bus.MODE;
          len_d   = bus.LEN;
          idx_d   = '0;
          gen_d   = (bus.MODE == MODE_LFSR) ? LFSR_INIT : SEED_W;
          state_d = (bus.LEN == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        bus.VALID = 1'b1;
        bus.BUSY  = 1'b1;
        bus.WORD  = cur_word;
        bus.LAST  = is_last;
        if (bus.READY) begin
          idx_d = idx_q + LEN_W'(1);
          gen_d = next_gen;
          if (is_last) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        bus.BUSY = 1'b1;
        bus.DONE = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_test_word_gen.sv
// tb/tb_test_word_gen.sv - vector and random burst bench for test_word_gen against a reference model
module tb_test_word_gen;
  localparam int WIDTH = 32;
  localparam int LEN_W = 6;
  localparam int NDUT  = 3;
  localparam int OW    = WIDTH + 4;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic C = 1'b0;
  logic R = 1'b0;
  always #5 C = ~C;

  logic             start = 1'b0;
  logic [1:0]       mode  = 2'd0;
  logic [LEN_W-1:0] len   = '0;
  logic             ready = 1'b0;

  test_word_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) if0 ();
  test_word_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) if1 ();
  test_word_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) if2 ();

  assign if0.START = start; assign if0.MODE = mode; assign if0.LEN = len; assign if0.READY = ready;
  assign if1.START = start; assign if1.MODE = mode; assign if1.LEN = len; assign if1.READY = ready;
  assign if2.START = start; assign if2.MODE = mode; assign if2.LEN = len; assign if2.READY = ready;

  test_word_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .SEED(32'h0000_0001), .POLY(POLY))
    dut0 (.C(C), .R(R), .bus(if0.master));
  test_word_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .SEED(32'hFFFF_FFFE), .POLY(POLY))
    dut1 (.C(C), .R(R), .bus(if1.master));
  test_word_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .SEED(32'h0000_0000), .POLY(POLY))
    dut2 (.C(C), .R(R), .bus(if2.master));

  logic [OW-1:0] obs [NDUT];
  assign obs[0] = {if0.WORD, if0.VALID, if0.LAST, if0.BUSY, if0.DONE};
  assign obs[1] = {if1.WORD, if1.VALID, if1.LAST, if1.BUSY, if1.DONE};
  assign obs[2] = {if2.WORD, if2.VALID, if2.LAST, if2.BUSY, if2.DONE};

  int checks = 0;
  int errors = 0;
  bit pat_q[$];

  function automatic logic [31:0] seed_of(int d);
    case (d)
      0:       return 32'h0000_0001;
      1:       return 32'hFFFF_FFFE;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] tbl(int k);
    logic [31:0] t [8] = '{32'h0000_0000, 32'h0000_0001, 32'h1234_5678, 32'hABCD_EF00,
                           32'hBAD0_E0F0, 32'hFFFF_FFFF, 32'h0128_0256, 32'hAAAA_AAAA};
    return t[k % 8];
  endfunction

  // k-th word of a burst, derived from the mode rules alone
  function automatic logic [31:0] model_word(logic [31:0] seed, int m, int k);
    logic [31:0] s;
    case (m)
      0: return tbl(k);
      1: return seed + 32'(k);
      2: begin
        s = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
        return s;
      end
      default: return seed;
    endcase
  endfunction

  task automatic check_one(string name, int d, logic [OW-1:0] exp);
    checks++;
    if (obs[d] !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got word=%h v/l/b/d=%b want word=%h v/l/b/d=%b",
               name, d, obs[d][OW-1:4], obs[d][3:0], exp[OW-1:4], exp[3:0]);
    end
  endtask

  // phase 0: word k offered; 1: done pulse; 2: idle
  task automatic check_all(string name, int m, int k, int n, int phase);
    logic [OW-1:0] exp;
    for (int d = 0; d < NDUT; d++) begin
      case (phase)
        0:       exp = {model_word(seed_of(d), m, k), 1'b1, (k == n - 1), 1'b1, 1'b0};
        1:       exp = {32'd0, 4'b0011};
        default: exp = '0;
      endcase
      check_one(name, d, exp);
    end
  endtask

  task automatic run_burst(string name, int m, int n, int rmode, bit poke, bit sfin, output int hs);
    int k;
    int cyc;
    bit r;
    @(negedge C);
    start = 1'b1; mode = 2'(m); len = LEN_W'(n); ready = 1'b1;
    @(negedge C);
    start = 1'b0;
    k = 0; cyc = 0; hs = 0;
    while (k < n && cyc < 400) begin
      check_all(name, m, k, n, 0);
      case (rmode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = (pat_q.size() > 0) ? pat_q.pop_front() : 1'b1;
      endcase
      ready = r;
      if (poke && cyc == 1) begin
        start = 1'b1; len = LEN_W'(n + 5);
      end else begin
        start = 1'b0;
      end
      if (r && if0.VALID) hs++;
      @(negedge C);
      if (r) k++;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (k < n) begin
      errors++;
      $display("FAIL %s timeout got %0d words want %0d", name, k, n);
    end
    check_all({name, "_fin"}, m, 0, n, 1);
    start = sfin;
    @(negedge C);
    start = 1'b0;
    check_all({name, "_idle"}, m, 0, n, 2);
  endtask

  typedef struct {
    int mode;
    int len;
    int rmode;
    bit poke;
    bit sfin;
    int exp_hs;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int hs;
    vecs[0] = '{0, 9, 0, 0, 0, 9};
    vecs[1] = '{1, 3, 0, 0, 0, 3};
    vecs[2] = '{2, 3, 0, 0, 0, 3};
    vecs[3] = '{3, 5, 1, 0, 0, 5};
    vecs[4] = '{0, 0, 0, 0, 1, 0};
    vecs[5] = '{0, 1, 0, 0, 0, 1};
    vecs[6] = '{0, 6, 1, 1, 0, 6};
    vecs[7] = '{2, 20, 1, 0, 1, 20};
    vecs[8] = '{1, 63, 0, 0, 0, 63};
    for (int i = 9; i < 16; i++) begin
      vecs[i].mode   = $urandom_range(0, 3);
      vecs[i].len    = $urandom_range(0, 20);
      vecs[i].rmode  = 1;
      vecs[i].poke   = $urandom_range(0, 1);
      vecs[i].sfin   = $urandom_range(0, 1);
      vecs[i].exp_hs = vecs[i].len;
    end

    #12;
    check_all("reset", 0, 0, 0, 2);
    @(negedge C);
    R = 1'b1;

    foreach (vecs[i]) begin
      run_burst($sformatf("vec%0d", i), vecs[i].mode, vecs[i].len, vecs[i].rmode,
                vecs[i].poke, vecs[i].sfin, hs);
      checks++;
      if (hs != vecs[i].exp_hs) begin
        errors++;
        $display("FAIL vec%0d_handshakes got %0d want %0d", i, hs, vecs[i].exp_hs);
      end
    end

    pat_q = '{1, 0, 0, 1, 1, 0, 1};
    run_burst("backpressure", 0, 4, 2, 1'b0, 1'b0, hs);
    checks++;
    if (hs != 4) begin
      errors++;
      $display("FAIL backpressure_handshakes got %0d want 4", hs);
    end

    @(negedge C);
    start = 1'b1; mode = 2'd0; len = LEN_W'(8); ready = 1'b1;
    @(negedge C);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_all("midreset_run", 0, k, 8, 0);
      if (k < 2) @(negedge C);
    end
    #1 R = 1'b0;
    #1 check_all("midreset_now", 0, 0, 0, 2);
    @(negedge C);
    check_all("midreset_hold", 0, 0, 0, 2);
    @(negedge C);
    check_all("midreset_nodone", 0, 0, 0, 2);
    R = 1'b1;
    run_burst("after_reset", 0, 3, 0, 1'b0, 1'b0, hs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
